// File: rtl/sd_buf_arb.sv
// Arbiter for the single-port 512-byte block buffer: SD data engine (D) has fixed priority,
// OTP XOR engine (O) is protected by a starvation guard; RAM side is fully registered.
module sd_buf_arb #(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_LIM = 15
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              ireq_d,
  input  logic              iwe_d,
  input  logic [ADDR_W-1:0] iaddr_d,
  input  logic [DATA_W-1:0] iwdata_d,
  output logic              ogrant_d,
  output logic              ovalid_d,
  input  logic              ireq_o,
  input  logic              iwe_o,
  input  logic [ADDR_W-1:0] iaddr_o,
  input  logic [DATA_W-1:0] iwdata_o,
  output logic              ogrant_o,
  output logic              ovalid_o,
  output logic [DATA_W-1:0] ordata,
  output logic              oram_en,
  output logic              oram_we,
  output logic [ADDR_W-1:0] oram_addr,
  output logic [DATA_W-1:0] oram_wdata,
  input  logic [DATA_W-1:0] irdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_O    = 2'd2
  } owner_e;

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  owner_e            own_q, own_d;
  logic              valid_d_q, valid_d_d;
  logic              valid_o_q, valid_o_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              force_grant;
  logic              gnt_d, gnt_o;

  // Grant decision: O wins only when D is idle or O has waited STARVE_LIM cycles
  always_comb begin
    force_grant = (starve_cnt_q == CNT_W'(STARVE_LIM));
    gnt_o       = !irst && ireq_o && (!ireq_d || force_grant);
    gnt_d       = !irst && ireq_d && !gnt_o;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    ram_en_d     = gnt_d || gnt_o;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    own_d        = OWN_NONE;
    valid_d_d    = (own_q == OWN_D);
    valid_o_d    = (own_q == OWN_O);

    if (gnt_o || !ireq_o) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_W'(STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (gnt_o) begin
      ram_we_d    = iwe_o;
      ram_addr_d  = iaddr_o;
      ram_wdata_d = iwdata_o;
      if (!iwe_o) own_d = OWN_O;
    end else if (gnt_d) begin
      ram_we_d    = iwe_d;
      ram_addr_d  = iaddr_d;
      ram_wdata_d = iwdata_d;
      if (!iwe_d) own_d = OWN_D;
    end
  end

  // Reset drops any in-flight read tag so no stale valid appears after release
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      starve_cnt_q <= '0;
      own_q        <= OWN_NONE;
      valid_d_q    <= 1'b0;
      valid_o_q    <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      own_q        <= own_d;
      valid_d_q    <= valid_d_d;
      valid_o_q    <= valid_o_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign ogrant_d   = gnt_d;
  assign ogrant_o   = gnt_o;
  assign ovalid_d   = valid_d_q;
  assign ovalid_o   = valid_o_q;
  assign ordata     = irdata;
  assign oram_en    = ram_en_q;
  assign oram_we    = ram_we_q;
  assign oram_addr  = ram_addr_q;
  assign oram_wdata = ram_wdata_q;

endmodule
